// File: rtl/coin_balance.sv
// coin_balance: debounced coin buttons feeding a saturating 3-digit BCD balance with charge handshake
module coin_balance #(
  parameter int          DEB_CYCLES = 2_000_000,
  parameter logic [11:0] MAX_BAL    = 12'h999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  coin_btn,
  input  logic        clr,
  input  logic        charge_req,
  input  logic [11:0] charge_amt,
  output logic [11:0] bal,
  output logic        bal_full,
  output logic        charge_ack,
  output logic        charge_nack
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, CLR, ADD, CHG} state_t;
  state_t          r_state, w_next;
  logic [2:0]      r_s1, r_s2, r_deb, r_deb_q, r_pend, w_press, w_sel;
  logic [CW-1:0]   r_cnt [3];
  logic [11:0]     r_bal, r_amt, w_add_val;
  logic [12:0]     w_sum, w_diff;
  logic            w_amt_ok, w_sufficient, r_ack, r_nack;

  // digit-wise BCD add; bit 12 is the carry out of the hundreds digit
  function automatic logic [12:0] bcd_add(input logic [11:0] a, input logic [11:0] b);
    logic [4:0]  s;
    logic        c;
    logic [11:0] r;
    c = 1'b0;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      s = {1'b0, a[4*i+:4]} + {1'b0, b[4*i+:4]} + {4'd0, c};
      c = s > 5'd9;
      r[4*i+:4] = c ? 4'(s - 5'd10) : s[3:0];
    end
    return {c, r};
  endfunction

  // digit-wise BCD subtract; bit 12 is the borrow out, set when b > a
  function automatic logic [12:0] bcd_sub(input logic [11:0] a, input logic [11:0] b);
    logic [4:0]  d;
    logic        br;
    logic [11:0] r;
    br = 1'b0;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      d = {1'b0, a[4*i+:4]} - {1'b0, b[4*i+:4]} - {4'd0, br};
      br = d[4];
      r[4*i+:4] = br ? 4'(d + 5'd10) : d[3:0];
    end
    return {br, r};
  endfunction

  assign w_press      = r_deb & ~r_deb_q;
  assign w_sel        = r_pend & (~r_pend + 3'd1);
  assign w_add_val    = w_sel[0] ? 12'h001 : w_sel[1] ? 12'h005 : 12'h010;
  assign w_sum        = bcd_add(r_bal, w_add_val);
  assign w_diff       = bcd_sub(r_bal, r_amt);
  assign w_amt_ok     = r_amt[3:0] <= 4'd9 && r_amt[7:4] <= 4'd9 && r_amt[11:8] <= 4'd9;
  assign w_sufficient = w_amt_ok & ~w_diff[12];
  assign bal          = r_bal;
  assign bal_full     = r_bal == MAX_BAL;
  assign charge_ack   = r_ack;
  assign charge_nack  = r_nack;

  // synchronise raw buttons and accept a new level only after it holds DEB_CYCLES cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_deb   <= '0;
      r_deb_q <= '0;
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else begin
      r_s1    <= coin_btn;
      r_s2    <= r_s1;
      r_deb_q <= r_deb;
      for (int i = 0; i < 3; i++) begin
        if (r_s2[i] == r_deb[i]) r_cnt[i] <= '0;
        else if (r_cnt[i] == CW'(DEB_CYCLES - 1)) begin
          r_cnt[i] <= '0;
          r_deb[i] <= ~r_deb[i];
        end else r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;
  end

  // next state: IDLE dispatches by priority clr > charge > add; every other state returns to IDLE
  always_comb begin
    w_next = IDLE;
    if (r_state == IDLE) w_next = clr ? CLR : charge_req ? CHG : |(r_pend | w_press) ? ADD : IDLE;
  end

  // balance, latched charge amount, pending presses and handshake pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bal  <= '0;
      r_amt  <= '0;
      r_pend <= '0;
      r_ack  <= 1'b0;
      r_nack <= 1'b0;
    end else begin
      r_ack  <= r_state == CHG && w_sufficient;
      r_nack <= r_state == CHG && !w_sufficient;
      if (r_state == IDLE && !clr && charge_req) r_amt <= charge_amt;
      r_pend <= r_state == CLR ? w_press : (r_pend & ~(r_state == ADD ? w_sel : 3'b000)) | w_press;
      if (r_state == CLR) r_bal <= '0;
      else if (r_state == ADD) r_bal <= w_sum > {1'b0, MAX_BAL} ? MAX_BAL : w_sum[11:0];
      else if (r_state == CHG && w_sufficient) r_bal <= w_diff[11:0];
    end
  end
endmodule

// File: tb/tb_coin_balance.sv
// tb_coin_balance: table-driven scoreboard bench for coin_balance
module tb_coin_balance;
  typedef enum {K_PRESS, K_CHG, K_CLR} kind_t;
  typedef struct {
    kind_t       kind;
    int          btn;
    logic [11:0] amt;
    logic [11:0] bal;
    logic        full;
    logic        ack;
    logic        nack;
  } vec_t;

  logic        clk = 1'b0, rst = 1'b0, clr = 1'b0, charge_req = 1'b0;
  logic [2:0]  coin_btn = 3'b000;
  logic [11:0] charge_amt = 12'h000;
  logic [11:0] bal;
  logic        bal_full, charge_ack, charge_nack;
  int          checks = 0, failures = 0;
  vec_t        vecs[$];
  vec_t        sb[$];

  coin_balance #(.DEB_CYCLES(4), .MAX_BAL(12'h999)) dut (
    .clk(clk), .rst(rst), .coin_btn(coin_btn), .clr(clr), .charge_req(charge_req),
    .charge_amt(charge_amt), .bal(bal), .bal_full(bal_full), .charge_ack(charge_ack),
    .charge_nack(charge_nack)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(input int n);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic void add_vec(input kind_t k, input int b, input logic [11:0] a, input int dec_bal,
                                  input logic ack, input logic nack);
    vec_t v;
    v.kind = k;
    v.btn  = b;
    v.amt  = a;
    v.bal  = to_bcd(dec_bal);
    v.full = dec_bal == 999;
    v.ack  = ack;
    v.nack = nack;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic press(input int b);
    @(posedge clk); #1 coin_btn[b] = 1'b1;
    repeat (8) @(posedge clk);
    #1 coin_btn[b] = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic charge(input logic [11:0] amt, output logic [1:0] pulse, output logic [1:0] stray);
    @(posedge clk); #1 charge_req = 1'b1; charge_amt = amt;
    @(posedge clk); #1 charge_req = 1'b0; charge_amt = ~amt;
    @(negedge clk); stray[0] = charge_ack | charge_nack;
    @(posedge clk); @(negedge clk); pulse = {charge_ack, charge_nack};
    @(posedge clk); @(negedge clk); stray[1] = charge_ack | charge_nack;
  endtask

  initial begin
    vec_t       e;
    logic [1:0] pulse, stray;
    logic       seen;
    for (int k = 1; k <= 9; k++) add_vec(K_PRESS, 2, 12'h0, 5 + 10 * k, 0, 0);
    add_vec(K_PRESS, 2, 12'h0, 105, 0, 0);
    for (int k = 1; k <= 5; k++) add_vec(K_PRESS, 0, 12'h0, 105 + k, 0, 0);
    add_vec(K_PRESS, 2, 12'h0, 120, 0, 0);
    add_vec(K_CHG, 0, 12'h085, 35, 1, 0);
    add_vec(K_CHG, 0, 12'h040, 35, 0, 1);
    add_vec(K_CHG, 0, 12'h000, 35, 1, 0);
    add_vec(K_CHG, 0, 12'h0A0, 35, 0, 1);
    add_vec(K_CHG, 0, 12'h036, 35, 0, 1);
    add_vec(K_CHG, 0, 12'h035, 0, 1, 0);
    add_vec(K_PRESS, 1, 12'h0, 5, 0, 0);
    add_vec(K_CLR, 0, 12'h0, 0, 0, 0);
    for (int k = 1; k <= 99; k++) add_vec(K_PRESS, 2, 12'h0, 10 * k, 0, 0);
    add_vec(K_PRESS, 1, 12'h0, 995, 0, 0);
    add_vec(K_PRESS, 2, 12'h0, 999, 0, 0);
    add_vec(K_PRESS, 0, 12'h0, 999, 0, 0);
    add_vec(K_PRESS, 1, 12'h0, 999, 0, 0);
    add_vec(K_CHG, 0, 12'h999, 0, 1, 0);
    add_vec(K_CHG, 0, 12'h001, 0, 0, 1);
    add_vec(K_PRESS, 2, 12'h0, 10, 0, 0);

    repeat (3) @(negedge clk);
    chk("reset bal", bal, 12'h000);
    chk("reset full", 12'(bal_full), 12'h0);
    chk("reset ack/nack", 12'({charge_ack, charge_nack}), 12'h0);
    @(posedge clk); #1 rst = 1'b1;

    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      #1 coin_btn[1] = (i % 2 == 0);
      @(posedge clk);
    end
    #1 coin_btn[1] = 1'b1;
    @(negedge clk);
    chk("bounce quiet", bal, 12'h000);
    repeat (8) @(posedge clk);
    #1 coin_btn[1] = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("bounce single +5", bal, 12'h005);

    foreach (vecs[i]) begin
      sb.push_back(vecs[i]);
      pulse = 2'b00;
      stray = 2'b00;
      case (vecs[i].kind)
        K_PRESS: press(vecs[i].btn);
        K_CHG:   charge(vecs[i].amt, pulse, stray);
        default: begin
          @(posedge clk); #1 clr = 1'b1;
          @(posedge clk); #1 clr = 1'b0;
          repeat (2) @(posedge clk);
          @(negedge clk);
        end
      endcase
      e = sb.pop_front();
      chk($sformatf("vec%0d bal", i), bal, e.bal);
      chk($sformatf("vec%0d full", i), 12'(bal_full), 12'(e.full));
      if (e.kind == K_CHG) begin
        chk($sformatf("vec%0d ack/nack", i), 12'(pulse), 12'({e.ack, e.nack}));
        chk($sformatf("vec%0d pulse width", i), 12'(stray), 12'h0);
      end
    end

    @(posedge clk); #1 coin_btn[0] = 1'b1;
    repeat (6) @(posedge clk);
    #1 charge_req = 1'b1; charge_amt = 12'h010;
    @(posedge clk); #1 charge_req = 1'b0; charge_amt = 12'h000;
    @(negedge clk);
    chk("same-cycle early pulse", 12'({charge_ack, charge_nack}), 12'h0);
    @(posedge clk); @(negedge clk);
    chk("same-cycle ack", 12'({charge_ack, charge_nack}), 12'h2);
    chk("same-cycle bal after charge", bal, 12'h000);
    repeat (3) @(negedge clk);
    chk("same-cycle bal after add", bal, 12'h001);
    #1 coin_btn[0] = 1'b0;
    repeat (10) @(posedge clk);

    @(posedge clk); #1 charge_req = 1'b1; charge_amt = 12'h001;
    @(posedge clk); #1 charge_req = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("reset mid-CHG bal", bal, 12'h000);
    seen = charge_ack | charge_nack;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      seen = seen | charge_ack | charge_nack;
    end
    chk("reset mid-CHG no pulse", 12'(seen), 12'h0);
    chk("reset mid-CHG bal held", bal, 12'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
